ssd_scan_driver: RTL and testbench
==================================

# ssd_scan_driver

Consumer end of the lock controller's display bus. It takes four packed 5-bit character codes, holds them in a frame-synchronous shadow register, and time-multiplexes them onto a 4-digit common-anode seven-segment display. Selected digits blink at a programmable rate. It sits between the lock FSM's `ssd` code output and the board's anode and segment pins.

## Interface
- `SCAN_DIV`, default 100000: clock cycles per digit slot (≥4).
- `BLINK_DIV`, default 50000000: clock cycles per blink half-period (1 Hz at 100 MHz).
- `GUARD`, default 2: leading cycles of each slot with all anodes off. Only used when `SSD_GHOST_GUARD_EN` is defined; must be less than `SCAN_DIV`.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset. Synchronous, active-high.
- `codes` in 20: four character codes. `[19:15]` is digit 3 (leftmost), `[4:0]` is digit 0.
- `load` in 1: capture strobe for `codes`.
- `blink_mask` in 4: per-digit blink enable. Bit i controls digit i. Sampled live, not shadowed.
- `an` out 4: anodes, active-low.
- `seg` out 7: segments a..g, active-low. `seg[0]` is segment a.
- `frame_start` out 1: one-cycle pulse on the first cycle of the digit 0 slot.

## Operation
- Code map:
  - 0x00–0x0F: hex glyphs 0–F.
  - 0x10: blank.
  - 0x11: dash.
  - 0x12: L.
  - 0x13: P.
  - 0x14: U.
  - 0x15: n.
  - 0x16: o.
  - 0x17: r.
  - 0x18–0x1F: blank.
- Registers:
  - `pending[19:0]` and `pend_v`.
  - `active[19:0]`.
  - `slot_cnt`, `idx[1:0]`.
  - `blink_cnt`, `blink_ph`.
- Load path:
  - `load=1` writes `codes` into `pending` and sets `pend_v`.
  - At a frame boundary (`idx`=3 and `slot_cnt`=SCAN_DIV-1), if `pend_v`, then `active` takes `pending` and `pend_v` clears.
  - If `load` coincides with a boundary, `codes` goes directly to `active` and `pend_v` clears.
  - Repeated loads within a frame: only the last one is kept.
- Scan FSM:
  - Cycles through states `S0`→`S1`→`S2`→`S3`→`S0`, one state per digit (`idx`).
  - Each state lasts exactly SCAN_DIV cycles, with `slot_cnt` counting 0..SCAN_DIV-1.
- Blink:
  - `blink_cnt` counts 0..BLINK_DIV-1. On wrap, `blink_ph` toggles.
  - A digit is suppressed when `blink_ph`=1 and `blink_mask[idx]`=1.
  - A suppressed digit has `an`=4'b1111 and `seg`=7'h7F for its slot.
- Drive for a non-suppressed slot: `an` has only bit `idx` low, and `seg` is the decode of `active[5*idx+4 : 5*idx]`.

## Timing
- Reset values:
  - `an`=4'b1111, `seg`=7'h7F, `frame_start`=0.
  - `idx`=0, `slot_cnt`=0, `blink_cnt`=0, `blink_ph`=0.
  - `active`=`pending`=all 0x10 (blank), `pend_v`=0.
- Reset is synchronous: it takes effect at the first rising edge with `rst`=1. Asserting `rst` mid-scan discards pending codes and restarts at `S0`.
- `an`, `seg` and `frame_start` are registered, one cycle behind `idx`/`slot_cnt`.
- After `rst` deasserts, the first cycle after release has `idx`=0 and `slot_cnt`=0. The outputs for that state appear on the following cycle, with `frame_start`=1.
- Load latency: new codes appear in the `seg` output of digit 0 no later than 1 frame + 1 cycle after the `load` edge, where 1 frame = 4·SCAN_DIV cycles. Codes never change mid-frame.
- A `blink_ph` toggle takes effect on the next cycle's outputs, even mid-slot.
- Counters wrap silently. There is no overflow flag.

## Configuration
- `SSD_GHOST_GUARD_EN` defined: for `slot_cnt` < GUARD, `an`=4'b1111 and `seg`=7'h7F. Normal drive resumes from `slot_cnt`=GUARD. This removes ghosting between adjacent digits.
- `SSD_GHOST_GUARD_EN` undefined: anodes are driven for the full slot, and the GUARD parameter is ignored.

## Structure
- Package `ssd_pkg`:
  - Code constants `SSD_BLANK`=5'h10, `SSD_DASH`=5'h11, `SSD_L`, `SSD_P`, `SSD_U`, `SSD_N`, `SSD_O`, `SSD_R`.
  - `SEG_OFF`=7'h7F.
  - Typedef `ssd_code_t` (5-bit).
  - The lock FSM imports the same constants.
- Sub-module `ssd_glyph_decode`: purely combinational, 5-bit code → 7-bit active-low segments. It is instantiated once and fed by the mux on `idx`.

## Test plan
All scenarios use SCAN_DIV=4, BLINK_DIV=16 and GUARD=1.
- Reset: hold `rst` 3 cycles, then release.
  - Before any load, every slot shows `an` walking 1110→1101→1011→0111, each for 4 cycles, with `seg`=7'h7F throughout.
  - `frame_start` pulses every 16 cycles.
- Load "CLSD": pulse `load` with `codes`={0x0C,0x12,0x05,0x0D} mid-frame.
  - The next frame shows digit 0 `seg`=7'h21 (d), digit 1 7'h12 (5), digit 2 7'h47 (L), digit 3 7'h46 (C).
  - The current frame is unchanged.
- Double load: load 0x00000, then 0xFFFFF (all 0x1F) in the same frame.
  - Only blank is displayed next frame. The zeros are never displayed.
- Load on boundary: assert `load` exactly when `idx`=3 and `slot_cnt`=3.
  - The new codes are shown from the very next digit 0 slot.
- Blink: `blink_mask`=4'b0001 with "0123" loaded.
  - Digit 0 is shown for 16 cycles, then `an`=1111 during the digit 0 slots for the next 16 cycles, repeating.
  - Digits 1–3 are unaffected.
- Guard and reset mid-scan:
  - With `SSD_GHOST_GUARD_EN`, the first cycle of every slot has `an`=1111.
  - Asserting `rst` during `S2` with `pend_v`=1 yields `S0`, blank output, and `pend_v`=0 on the next cycle.

Source files
------------

// File: rtl/ssd_pkg.sv
// ssd_pkg: shared display-bus definitions.
//   Character code constants (also imported by the lock FSM), the
//   all-segments-off pattern, the code typedef and the scan state enum.
package ssd_pkg;

    localparam int NUM_DIGITS = 4;
    localparam int CODE_W     = 5;

    typedef logic [CODE_W-1:0] ssd_code_t;

    // 0x00-0x0F are hex glyphs; letters live above them.
    localparam ssd_code_t SSD_BLANK = 5'h10;
    localparam ssd_code_t SSD_DASH  = 5'h11;
    localparam ssd_code_t SSD_L     = 5'h12;
    localparam ssd_code_t SSD_P     = 5'h13;
    localparam ssd_code_t SSD_U     = 5'h14;
    localparam ssd_code_t SSD_N     = 5'h15;
    localparam ssd_code_t SSD_O     = 5'h16;
    localparam ssd_code_t SSD_R     = 5'h17;

    // Active-low segments, bit 0 = a ... bit 6 = g.
    localparam logic [6:0] SEG_OFF = 7'h7F;

    // Encoding equals the digit index driven in that state.
    typedef enum logic [1:0] {S0 = 2'd0, S1 = 2'd1, S2 = 2'd2, S3 = 2'd3} scan_state_t;

endpackage

// File: rtl/ssd_glyph_decode.sv
// ssd_glyph_decode: combinational character code -> seven-segment pattern.
//   code : 5-bit character code (hex 0-F, blank, dash, L P U n o r)
//   seg  : active-low segments, seg[0] = a .. seg[6] = g
//   Unused codes (0x18-0x1F) decode to blank.
module ssd_glyph_decode
    import ssd_pkg::*;
(
    input  ssd_code_t  code,
    output logic [6:0] seg
);

    always_comb begin
        seg = SEG_OFF;
        case (code)
            5'h00:    seg = 7'h40;
            5'h01:    seg = 7'h79;
            5'h02:    seg = 7'h24;
            5'h03:    seg = 7'h30;
            5'h04:    seg = 7'h19;
            5'h05:    seg = 7'h12;
            5'h06:    seg = 7'h02;
            5'h07:    seg = 7'h78;
            5'h08:    seg = 7'h00;
            5'h09:    seg = 7'h10;
            5'h0A:    seg = 7'h08;
            5'h0B:    seg = 7'h03;
            5'h0C:    seg = 7'h46;
            5'h0D:    seg = 7'h21;
            5'h0E:    seg = 7'h06;
            5'h0F:    seg = 7'h0E;
            SSD_DASH: seg = 7'h3F;
            SSD_L:    seg = 7'h47;
            SSD_P:    seg = 7'h0C;
            SSD_U:    seg = 7'h41;
            SSD_N:    seg = 7'h2B;
            SSD_O:    seg = 7'h23;
            SSD_R:    seg = 7'h2F;
            default:  seg = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/ssd_scan_driver.sv
// ssd_scan_driver: 4-digit common-anode seven-segment scan driver.
//   Captures four 5-bit codes into a pending register, promotes them to the
//   displayed (active) register only at frame boundaries, scans one digit per
//   SCAN_DIV cycles and blanks blink-enabled digits on the odd blink phase.
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   codes[19:0]       : digit 3 in [19:15] .. digit 0 in [4:0]
//   load              : capture strobe for codes
//   blink_mask[3:0]   : per-digit blink enable, used live
//   an[3:0]           : anodes, active-low (registered)
//   seg[6:0]          : segments a..g, active-low (registered)
//   frame_start       : pulse on first output cycle of the digit 0 slot
// Build option: define SSD_GHOST_GUARD_EN to blank the first GUARD cycles of
//   every slot (anti-ghosting). Without it GUARD has no effect.
module ssd_scan_driver
    import ssd_pkg::*;
#(
    parameter int SCAN_DIV  = 100000,
    parameter int BLINK_DIV = 50000000,
    parameter int GUARD     = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [19:0] codes,
    input  logic        load,
    input  logic [3:0]  blink_mask,
    output logic [3:0]  an,
    output logic [6:0]  seg,
    output logic        frame_start
);

    localparam int SW = (SCAN_DIV  > 1) ? $clog2(SCAN_DIV)  : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [SW-1:0] SLOT_LAST  = SW'(SCAN_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_DIV - 1);
    localparam logic [SW-1:0] GUARD_CNT  = SW'(GUARD);

`ifdef SSD_GHOST_GUARD_EN
    localparam bit GUARD_EN = 1'b1;
`else
    localparam bit GUARD_EN = 1'b0;
`endif

    localparam logic [19:0] ALL_BLANK = {NUM_DIGITS{SSD_BLANK}};

    scan_state_t state_q, state_d;
    logic [1:0]      idx;
    logic [SW-1:0]   slot_cnt;
    logic [BW-1:0]   blink_cnt;
    logic            blink_ph;

    ssd_code_t [NUM_DIGITS-1:0] pending, active;
    logic                       pend_v;

    logic slot_end, frame_end;
    logic drive_on;
    ssd_code_t  cur_code;
    logic [6:0] glyph;
    logic [3:0] an_d;
    logic [6:0] seg_d;
    logic       fs_d;

    assign idx       = state_q;
    assign slot_end  = (slot_cnt == SLOT_LAST);
    assign frame_end = slot_end && (state_q == S3);

    // ---------------- scan FSM: state register ----------------
    always_ff @(posedge clk) begin
        if (rst) state_q <= S0;
        else     state_q <= state_d;
    end

    // ---------------- scan FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        if (slot_end) begin
            case (state_q)
                S0: state_d = S1;
                S1: state_d = S2;
                S2: state_d = S3;
                S3: state_d = S0;
                default: state_d = S0;
            endcase
        end
    end

    // slot and blink counters
    always_ff @(posedge clk) begin
        if (rst || slot_end) slot_cnt <= '0;
        else                 slot_cnt <= slot_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            blink_cnt <= '0;
            blink_ph  <= 1'b0;
        end else if (blink_cnt == BLINK_LAST) begin
            blink_cnt <= '0;
            blink_ph  <= ~blink_ph;
        end else begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    // Load path: codes reach active only at a frame boundary, so a frame is
    // never torn. A load landing on the boundary bypasses pending.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= ALL_BLANK;
            active  <= ALL_BLANK;
            pend_v  <= 1'b0;
        end else if (frame_end && load) begin
            active  <= codes;
            pend_v  <= 1'b0;
        end else begin
            if (load) begin
                pending <= codes;
                pend_v  <= 1'b1;
            end
            if (frame_end && pend_v) begin
                active <= pending;
                pend_v <= 1'b0;
            end
        end
    end

    // Single decoder shared by all digits, fed by the digit mux.
    assign cur_code = active[idx];

    ssd_glyph_decode u_decode (
        .code (cur_code),
        .seg  (glyph)
    );

    // ---------------- scan FSM: outputs ----------------
    always_comb begin
        drive_on = !(blink_ph && blink_mask[idx]);
        if (GUARD_EN && (slot_cnt < GUARD_CNT)) drive_on = 1'b0;
        an_d  = drive_on ? ~(4'b0001 << idx) : 4'b1111;
        seg_d = drive_on ? glyph : SEG_OFF;
        fs_d  = (state_q == S0) && (slot_cnt == '0);
    end

    // Outputs are registered, one cycle behind the scan position.
    always_ff @(posedge clk) begin
        if (rst) begin
            an          <= 4'b1111;
            seg         <= SEG_OFF;
            frame_start <= 1'b0;
        end else begin
            an          <= an_d;
            seg         <= seg_d;
            frame_start <= fs_d;
        end
    end

endmodule

// File: tb/tb_ssd_scan_driver.sv
// Bench for ssd_scan_driver: position-based reference model compared every
// cycle, plus literal expectations at hand-picked scan positions.
module tb_ssd_scan_driver;

    localparam int SD = 4;
    localparam int BD = 16;
    localparam int GD = 1;
    localparam int FR = 4 * SD;

`ifdef SSD_GHOST_GUARD_EN
    localparam bit GEN = 1'b1;
`else
    localparam bit GEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [19:0] codes;
    logic        load;
    logic [3:0]  blink_mask;
    logic [3:0]  an;
    logic [6:0]  seg;
    logic        frame_start;

    int errors = 0;
    int checks = 0;

    ssd_scan_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD), .GUARD(GD)) dut (
        .clk(clk), .rst(rst), .codes(codes), .load(load),
        .blink_mask(blink_mask), .an(an), .seg(seg), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // Lit segments per code, written as segment letters.
    function automatic string lit_of(input int c);
        case (c)
            0: return "abcdef";   1: return "bc";      2: return "abdeg";
            3: return "abcdg";    4: return "bcfg";    5: return "acdfg";
            6: return "acdefg";   7: return "abc";     8: return "abcdefg";
            9: return "abcdfg";   10: return "abcefg"; 11: return "cdefg";
            12: return "adef";    13: return "bcdeg";  14: return "adefg";
            15: return "aefg";    17: return "g";      18: return "def";
            19: return "abefg";   20: return "bcdef";  21: return "ceg";
            22: return "cdeg";    23: return "eg";
            default: return "";
        endcase
    endfunction

    function automatic logic [6:0] to_seg(input string t);
        logic [6:0] s;
        s = 7'h7F;
        for (int i = 0; i < t.len(); i++) s[int'(t[i]) - 97] = 1'b0;
        return s;
    endfunction

    // Reference model: mp is the scan position (cycles since reset release)
    // whose outputs the next edge produces. m_frame holds the codes of the
    // frame being shown; m_latest the most recent load.
    int          mp = 0;
    bit          mvalid = 1'b0;
    logic [19:0] m_latest, m_frame;
    logic [3:0]  e_an;
    logic [6:0]  e_seg;
    logic        e_fs;
    int          md, msl;
    bit          mon;

    always @(posedge clk) begin
        if (rst) begin
            mp = 0; mvalid = 1'b1;
            m_latest = {4{5'h10}}; m_frame = {4{5'h10}};
            e_an = 4'hF; e_seg = 7'h7F; e_fs = 1'b0;
        end else if (mvalid) begin
            md  = (mp / SD) % 4;
            msl = mp % SD;
            mon = !((((mp / BD) % 2) == 1) && blink_mask[md]);
            if (GEN && msl < GD) mon = 1'b0;
            e_an  = mon ? ~(4'b0001 << md) : 4'hF;
            e_seg = mon ? to_seg(lit_of(int'(m_frame[5*md +: 5]))) : 7'h7F;
            e_fs  = (mp % FR) == 0;
            if (load) m_latest = codes;
            if ((mp % FR) == FR - 1) m_frame = m_latest;
            mp++;
        end
    end

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (mvalid) begin
            checks++;
            if (an !== e_an || seg !== e_seg || frame_start !== e_fs) begin
                errors++;
                $display("FAIL model pos=%0d: an=%b seg=%h fs=%b, want an=%b seg=%h fs=%b",
                         mp - 1, an, seg, frame_start, e_an, e_seg, e_fs);
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    // Advance to the negedge where outputs show scan position q.
    task automatic goto(input int q);
        int n;
        n = 0;
        while ((mp - 1) != q && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            errors++; checks++;
            $display("FAIL goto_timeout: pos=%0d, want %0d", mp - 1, q);
        end
    endtask

    task automatic pulse_load(input logic [19:0] c);
        codes = c; load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; codes = '0; blink_mask = 4'b0000;
        repeat (3) @(negedge clk);
        chk("rst_an", 32'(an), 32'hF);
        chk("rst_seg", 32'(seg), 32'h7F);
        chk("rst_fs", 32'(frame_start), 32'h0);
        rst = 1'b0;

        goto(0);  chk("first_fs", 32'(frame_start), 32'h1);
        goto(1);  chk("d0_an", 32'(an), 32'hE);
                  chk("blank_seg", 32'(seg), 32'h7F);
        goto(5);  chk("d1_an", 32'(an), 32'hD);
        goto(16); chk("fs_period", 32'(frame_start), 32'h1);
        goto(17); chk("fs_pulse", 32'(frame_start), 32'h0);

        // CLSD, loaded mid-frame 1
        goto(19); pulse_load({5'h0C, 5'h12, 5'h05, 5'h0D});
        goto(25); chk("cur_frame_kept", 32'(seg), 32'h7F);
        goto(34); chk("clsd_d", 32'(seg), 32'h21);
        goto(38); chk("clsd_5", 32'(seg), 32'h12);
        goto(42); chk("clsd_L", 32'(seg), 32'h47);
        goto(46); chk("clsd_C", 32'(seg), 32'h46);
                  chk("d3_an", 32'(an), 32'h7);

        // double load: only the last one survives
        goto(49); pulse_load(20'h00000);
        goto(53); pulse_load(20'hFFFFF);
        goto(66); chk("dbl_blank_d0", 32'(seg), 32'h7F);
        goto(70); blink_mask = 4'b0001;
        goto(74); chk("dbl_blank_d2", 32'(seg), 32'h7F);

        // load exactly on the frame boundary (sampled at position 79)
        goto(78); pulse_load({5'h00, 5'h01, 5'h02, 5'h03});
        goto(82); chk("blink_off_an", 32'(an), 32'hF);
                  chk("blink_off_seg", 32'(seg), 32'h7F);
        goto(86); chk("bnd_d1_seg", 32'(seg), 32'h24);
                  chk("bnd_d1_an", 32'(an), 32'hD);
        goto(98); chk("blink_on_seg", 32'(seg), 32'h30);
        goto(114); chk("blink_off2_an", 32'(an), 32'hF);

        // reset during S2 with a pending load
        goto(116); pulse_load({4{5'h11}});
        goto(120); chk("pend_set", 32'(dut.pend_v), 32'h1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_an", 32'(an), 32'hF);
        chk("mid_rst_pend", 32'(dut.pend_v), 32'h0);
        chk("mid_rst_idx", 32'(dut.idx), 32'h0);
        chk("mid_rst_slot", 32'(dut.slot_cnt), 32'h0);
        rst = 1'b0;
        goto(34); chk("post_rst_blank", 32'(seg), 32'h7F);
        goto(40);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
